// File: rtl/lut_sweeper.sv
// Programmable 2^N-entry truth-table LUT with serial load, registered evaluation and exhaustive sweep.
// Optional build macro LUT_SWEEP_READY_EN adds sw_ready_i backpressure on sweep beats.
module lut_sweeper #(
    parameter int unsigned            N          = 4,
    parameter logic [(1 << N) - 1:0]  INIT_TABLE = 16'h212F
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_en_i,
    input  logic         cfg_bit_i,
    input  logic [N-1:0] in_vec_i,
    output logic         eval_out_o,
    input  logic         start_i,
    output logic [N-1:0] sw_vec_o,
    output logic         sw_out_o,
    output logic         sw_valid_o,
    output logic         busy_o,
    output logic         done_o,
`ifdef LUT_SWEEP_READY_EN
    input  logic         sw_ready_i,
`endif
    output logic [N:0]   ones_count_o
);

    localparam int unsigned   T        = 1 << N;
    localparam logic [N-1:0]  IDX_LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_DONE
    } state_e;

    state_e         state_q, state_d;
    logic [T-1:0]   table_q, table_d;
    logic [N-1:0]   idx_q, idx_d;
    logic [N:0]     ones_q, ones_d;
    logic           eval_q, eval_d;
    logic           sw_out;
    logic           sw_valid;
    logic           beat_go;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            table_q <= INIT_TABLE;
            idx_q   <= '0;
            ones_q  <= '0;
            eval_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            table_q <= table_d;
            idx_q   <= idx_d;
            ones_q  <= ones_d;
            eval_q  <= eval_d;
        end
    end

    assign sw_out   = table_q[idx_q];
    assign sw_valid = (state_q == S_SWEEP);

`ifdef LUT_SWEEP_READY_EN
    assign beat_go = sw_valid && sw_ready_i;
`else
    assign beat_go = sw_valid;
`endif

    always_comb begin
        state_d = state_q;
        table_d = table_q;
        idx_d   = idx_q;
        ones_d  = ones_q;
        // Evaluation reads the pre-edge table, so a same-cycle shift is not visible.
        eval_d  = table_q[in_vec_i];

        if (cfg_en_i && (state_q == S_IDLE)) begin
            table_d = {cfg_bit_i, table_q[T-1:1]};
        end

        unique case (state_q)
            S_IDLE: begin
                // A start coinciding with a config shift is dropped.
                if (start_i && !cfg_en_i) begin
                    state_d = S_SWEEP;
                    idx_d   = '0;
                    ones_d  = '0;
                end
            end
            S_SWEEP: begin
                if (beat_go) begin
                    ones_d = ones_q + {{N{1'b0}}, sw_out};
                    if (idx_q == IDX_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign eval_out_o   = eval_q;
    assign sw_vec_o     = idx_q;
    assign sw_out_o     = sw_out;
    assign sw_valid_o   = sw_valid;
    assign busy_o       = sw_valid;
    assign done_o       = (state_q == S_DONE);
    assign ones_count_o = ones_q;

endmodule
